scanline_buffer: RTL and testbench
==================================

SCANLINE_BUFFER -- requirements
Module: scanline_buffer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter SWAP_H, default 699: h_count value at which line banks swap; same column at which v_count advances.
REQ-003 SHALL have parameter PIX_W, default 30: pixel width as {R[9:0],G[9:0],B[9:0]}.
REQ-004 SHALL have port CLOCK_50  in  1  the single pixel clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port wr_data  in  PIX_W  next pixel from the upstream pixel source.
REQ-007 SHALL have port wr_valid  in  1  wr_data is valid.
REQ-008 SHALL have port wr_ready  out  1  buffer accepts a pixel; a transfer occurs when wr_valid and wr_ready are both high.
REQ-009 SHALL have port h_count  in  10  pixel column from the timing generator.
REQ-010 SHALL have port video_on  in  1  active-region flag from the timing generator.
REQ-011 SHALL have port px_r, px_g, px_b  out  10 each  registered pixel colour for the VGA DAC.
REQ-012 SHALL have port line_req  out  1  one-cycle pulse: the fill bank is empty and the next line may be streamed.
REQ-013 SHALL have port underrun  out  1  one-cycle pulse: a swap found the fill bank incomplete.

Function
REQ-014 SHALL hold two line banks of H_ACTIVE x PIX_W: one display bank and one fill bank; disp_sel selects the display bank.
REQ-015 Fill FSM SHALL have two states: FILL (wr_ready=1) and FULL (wr_ready=0).
REQ-016 In FILL, each transfer SHALL write wr_data to fill-bank address wr_cnt and increment wr_cnt; the transfer at wr_cnt=H_ACTIVE-1 SHALL go to FULL.
REQ-017 Swap event SHALL be the cycle with h_count==SWAP_H.
REQ-018 Swap in FULL SHALL toggle disp_sel, clear wr_cnt to 0, enter FILL and pulse line_req on the next cycle.
REQ-019 Swap in FILL SHALL leave disp_sel, the state and wr_cnt unchanged (the old line repeats) and pulse underrun on the next cycle; filling SHALL continue.
REQ-020 If the final transfer (wr_cnt=H_ACTIVE-1) and a swap coincide, the transfer SHALL complete and the swap SHALL be handled as in FULL.
REQ-021 Read address SHALL be h_count[9:0] into the display bank; px_* SHALL appear exactly 1 cycle after the h_count that selected them.
REQ-022 px_r/g/b SHALL be 0 on the cycle after any cycle with video_on=0 or h_count>=H_ACTIVE.
REQ-023 wr_data bit mapping SHALL be R=[29:20], G=[19:10], B=[9:0].
REQ-024 wr_valid without wr_ready SHALL have no effect; wr_data SHALL NOT be sampled then.

Reset
REQ-025 While RESET_N=0 all outputs SHALL be 0, including wr_ready, line_req, underrun and px_*.
REQ-026 Reset SHALL set state=FILL, wr_cnt=0 and disp_sel=0; bank contents SHALL be undefined.
REQ-027 On the first clock after RESET_N rises, wr_ready SHALL be 1 and line_req SHALL pulse once.
REQ-028 Reset asserted mid-line or mid-fill SHALL discard the partial fill; no underrun pulse SHALL result from it.

Structure
REQ-029 H_ACTIVE, SWAP_H, PIX_W and the fill-state enum SHALL live in a shared package vga_pkg, which the timing generator also uses.
REQ-030 Storage SHALL be one sub-module line_ram: a simple dual-port RAM of 2*H_ACTIVE words with a registered read; the bank bit is the address MSB.

Verification
REQ-031 Stream 640 pixels with value i, then run to h_count=699 -> one line_req pulse; on the next line px_b=i at h_count=i+1.
REQ-032 wr_valid held high continuously -> wr_ready drops the cycle after the 640th transfer; exactly 640 transfers occur.
REQ-033 Only 300 pixels written by h_count=699 -> one underrun pulse; the previous line repeats; line_req stays 0.
REQ-034 640th transfer on the same cycle as h_count=699 -> swap occurs, line_req pulses, no underrun.
REQ-035 RESET_N pulsed low at wr_cnt=200 -> all outputs 0 within the same cycle; after release, wr_cnt=0 and line_req pulses once.
REQ-036 video_on=0 with the bank full of 0x3FFFFFFF -> px_r=px_g=px_b=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the line-fill state type, common to the
// scanline buffer and the timing generator.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int SWAP_H   = 699;
  localparam int H_TOTAL  = 800;
  localparam int PIX_W    = 30;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;
endpackage

// File: rtl/line_ram.sv
// Simple dual-port line store: two banks of BANK_WORDS pixels, the bank bit is
// the address MSB; the read port is registered.
module line_ram #(
  parameter int BANK_WORDS = 640,
  parameter int DATA_W     = 30,
  parameter int AW         = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2][BANK_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1]][waddr[AW-2:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr[AW-1]][raddr[AW-2:0]];
  end
endmodule

// File: rtl/scanline_buffer.sv
// Double-buffered scanline store: one bank is streamed to the DAC by h_count
// while the other is filled from the pixel source, banks swapping at SWAP_H.
module scanline_buffer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int SWAP_H   = vga_pkg::SWAP_H,
  parameter int PIX_W    = vga_pkg::PIX_W
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [9:0]       h_count,
  input  logic             video_on,
  output logic [9:0]       px_r,
  output logic [9:0]       px_g,
  output logic [9:0]       px_b,
  output logic             line_req,
  output logic             underrun
);
  localparam int LW = $clog2(H_ACTIVE);
  localparam int AW = LW + 1;
  localparam logic [9:0]    H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0]    SWAP_C  = 10'(SWAP_H);
  localparam logic [LW-1:0] LAST_C  = LW'(H_ACTIVE - 1);

  fill_state_t      state, state_nxt;
  logic [LW-1:0]    wr_cnt, wr_cnt_nxt;
  logic             disp_sel, disp_sel_nxt;
  logic             started;
  logic             line_req_nxt, underrun_nxt;
  logic             xfer, last_xfer, swap;
  logic             blank_p1;
  logic [PIX_W-1:0] rd_data_p1;

  // started holds everything quiet until the first clock after reset release
  assign wr_ready  = started && (state == FILL);
  assign xfer      = wr_valid && wr_ready;
  assign last_xfer = xfer && (wr_cnt == LAST_C);
  assign swap      = started && (h_count == SWAP_C);

  always_comb begin
    state_nxt    = state;
    wr_cnt_nxt   = wr_cnt;
    disp_sel_nxt = disp_sel;
    line_req_nxt = 1'b0;
    underrun_nxt = 1'b0;
    if (xfer) begin
      wr_cnt_nxt = wr_cnt + 1'b1;
      if (last_xfer) state_nxt = FULL;
    end
    // a final pixel landing on the swap column still counts as a full bank
    if (swap) begin
      if (state == FULL || last_xfer) begin
        disp_sel_nxt = ~disp_sel;
        wr_cnt_nxt   = '0;
        state_nxt    = FILL;
        line_req_nxt = 1'b1;
      end else begin
        underrun_nxt = 1'b1;
      end
    end
    if (!started) line_req_nxt = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= FILL;
      wr_cnt   <= '0;
      disp_sel <= 1'b0;
      started  <= 1'b0;
      line_req <= 1'b0;
      underrun <= 1'b0;
      blank_p1 <= 1'b1;
    end else begin
      state    <= state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      disp_sel <= disp_sel_nxt;
      started  <= 1'b1;
      line_req <= line_req_nxt;
      underrun <= underrun_nxt;
      blank_p1 <= !(video_on && (h_count < H_ACT_C));
    end
  end

  line_ram #(
    .BANK_WORDS(H_ACTIVE),
    .DATA_W    (PIX_W),
    .AW        (AW)
  ) u_line_ram (
    .clk  (CLOCK_50),
    .we   (xfer),
    .waddr({~disp_sel, wr_cnt}),
    .wdata(wr_data),
    .re   (h_count < H_ACT_C),
    .raddr({disp_sel, h_count[LW-1:0]}),
    .rdata(rd_data_p1)
  );

  // p1: RAM read and blanking flag both refer to the previous h_count
  assign px_r = blank_p1 ? 10'd0 : rd_data_p1[29:20];
  assign px_g = blank_p1 ? 10'd0 : rd_data_p1[19:10];
  assign px_b = blank_p1 ? 10'd0 : rd_data_p1[9:0];
endmodule

// File: tb/tb_scanline_buffer.sv
// Directed bench for scanline_buffer: bench-side timing generator and pixel
// source with hand-derived expectations for fill, swap, underrun and reset.
module tb_scanline_buffer;
  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic [29:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  h_count;
  logic        video_on;
  logic [9:0]  px_r, px_g, px_b;
  logic        line_req;
  logic        underrun;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_xfer, n_req, n_und, src_i, xfer_limit;
  bit fill_ones, vo_off;
  logic [9:0] last_h;

  always #5 CLOCK_50 = ~CLOCK_50;

  scanline_buffer dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .wr_data (wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .h_count (h_count),
    .video_on(video_on),
    .px_r    (px_r),
    .px_g    (px_g),
    .px_b    (px_b),
    .line_req(line_req),
    .underrun(underrun)
  );

  function automatic logic [29:0] pix(input int i);
    logic [9:0] r, g, b;
    r = 10'((i * 3) & 1023);
    g = 10'(1023 - (i & 1023));
    b = 10'(i & 1023);
    return {r, g, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    wr_data = fill_ones ? 30'h3FFF_FFFF : pix(src_i);
  endtask

  task automatic tick();
    bit acc;
    acc = wr_valid && wr_ready;
    @(posedge CLOCK_50);
    #1;
    last_h = h_count;
    if (acc) begin
      n_xfer++;
      src_i++;
      if (n_xfer >= xfer_limit) wr_valid = 1'b0;
    end
    if (line_req) n_req++;
    if (underrun) n_und++;
    h_count  = (h_count == 10'd799) ? 10'd0 : h_count + 10'd1;
    video_on = (h_count < 10'd640) && !vo_off;
    drive_src();
  endtask

  task automatic run_until_h(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_h != 10'(target) && n < 2000);
    if (last_h != 10'(target)) chk("timeout_h", 32'(last_h), 32'(target));
  endtask

  task automatic chk_px(input string tag, input logic [29:0] exp);
    chk(tag, {2'b00, px_r, px_g, px_b}, {2'b00, exp});
  endtask

  initial begin
    int n;
    RESET_N = 1'b0; wr_valid = 1'b0; h_count = 10'd0; video_on = 1'b1;
    vo_off = 1'b0; fill_ones = 1'b0; src_i = 0; xfer_limit = 100000;
    n_xfer = 0; n_req = 0; n_und = 0; last_h = '0;
    drive_src();
    repeat (3) tick();
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_line_req", 32'(line_req), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk_px("rst_px", 30'd0);

    // line 1: continuous valid, exactly 640 transfers then swap
    RESET_N = 1'b1; h_count = 10'd0; video_on = 1'b1;
    wr_valid = 1'b1; src_i = 0; drive_src(); n_req = 0; n_xfer = 0;
    tick();
    chk("rel_wr_ready", 32'(wr_ready), 1);
    chk("rel_line_req", 32'(line_req), 1);
    n = 0;
    while (n_xfer < 640 && n < 1000) begin tick(); n++; end
    chk("fill_xfers", 32'(n_xfer), 640);
    chk("full_wr_ready", 32'(wr_ready), 0);
    run_until_h(699);
    chk("swap1_line_req", 32'(line_req), 1);
    chk("swap1_req_cnt", 32'(n_req), 2);
    chk("held_valid_xfers", 32'(n_xfer), 640);
    wr_valid = 1'b0;

    // line 2: display pix(i); fill only 300 pixels -> underrun
    n_xfer = 0; xfer_limit = 300; wr_valid = 1'b1;
    run_until_h(0);   chk_px("disp_h0", pix(0));
    run_until_h(1);   chk_px("disp_h1", pix(1));
    run_until_h(100); chk_px("disp_h100", pix(100));
    run_until_h(639); chk_px("disp_h639", pix(639));
    run_until_h(640); chk_px("blank_h640", 30'd0);
    run_until_h(699);
    chk("under_pulse", 32'(underrun), 1);
    chk("under_no_req", 32'(line_req), 0);
    chk("under_wr_ready", 32'(wr_ready), 1);
    chk("under_xfers", 32'(n_xfer), 300);

    // line 3: old line repeats; last 340 pixels end exactly on the swap column
    run_until_h(10);  chk_px("repeat_h10", pix(10));
    run_until_h(359);
    xfer_limit = 640; wr_valid = 1'b1;
    run_until_h(699);
    chk("coinc_line_req", 32'(line_req), 1);
    chk("coinc_underrun", 32'(underrun), 0);
    chk("coinc_xfers", 32'(n_xfer), 640);
    chk("coinc_wr_ready", 32'(wr_ready), 1);
    chk("coinc_und_cnt", 32'(n_und), 1);

    // line 4: new bank visible, then reset in the middle of a fill
    run_until_h(5);   chk_px("swap2_h5", pix(645));
    run_until_h(400); chk_px("swap2_h400", pix(1040));
    n_xfer = 0; xfer_limit = 200; wr_valid = 1'b1;
    n = 0;
    while (n_xfer < 200 && n < 1000) begin tick(); n++; end
    chk("midfill_xfers", 32'(n_xfer), 200);
    RESET_N = 1'b0;
    #1;
    chk("arst_wr_ready", 32'(wr_ready), 0);
    chk("arst_line_req", 32'(line_req), 0);
    chk("arst_underrun", 32'(underrun), 0);
    chk_px("arst_px", 30'd0);
    repeat (2) tick();

    // line 5: after release the fill restarts at address 0 with all-ones data
    RESET_N = 1'b1; h_count = 10'd0; video_on = 1'b1;
    n_req = 0; n_und = 0; n_xfer = 0; xfer_limit = 100000;
    fill_ones = 1'b1; wr_valid = 1'b1; drive_src();
    tick();
    chk("rel2_line_req", 32'(line_req), 1);
    chk("rel2_wr_ready", 32'(wr_ready), 1);
    n = 0;
    while (wr_ready && n < 1000) begin tick(); n++; end
    chk("rel2_xfers", 32'(n_xfer), 640);
    run_until_h(699);
    chk("rel2_swap_req", 32'(line_req), 1);
    chk("rel2_req_cnt", 32'(n_req), 2);
    chk("rel2_und_cnt", 32'(n_und), 0);
    wr_valid = 1'b0;
    vo_off = 1'b1; video_on = 1'b0;

    // line 6: video_on low blanks a bank full of ones; line 7 shows it again
    run_until_h(5);   chk_px("vo_off_h5", 30'd0);
    run_until_h(100); chk_px("vo_off_h100", 30'd0);
    run_until_h(699);
    chk("empty_underrun", 32'(underrun), 1);
    vo_off = 1'b0;
    run_until_h(5);   chk_px("vo_on_h5", 30'h3FFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
